// File: rtl/port_hub.sv
// Memory-mapped I/O port hub: video memory write port, keyboard FIFO, SD SPI
// registers and video control, decoded at BASE+0..BASE+7.
module port_hub #(
  parameter logic [15:0] BASE   = 16'h0020,
  parameter int          PTR_W  = 18,
  parameter int          KBD_AW = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [15:0]      address,
  input  logic [7:0]       data_w,
  input  logic             we,
  input  logic             rd,
  input  logic [7:0]       ram_q,
  output logic [7:0]       data_r,
  output logic             intr,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_hit,
  output logic             mem_we,
  output logic             mem_sel,
  output logic [PTR_W-1:0] mem_addr,
  output logic [7:0]       mem_d,
  input  logic [7:0]       font_q,
  input  logic [3:0]       himm_q,
  output logic [7:0]       spi_out,
  output logic [1:0]       spi_cmd,
  output logic             spi_sent,
  input  logic [7:0]       spi_din,
  input  logic [1:0]       spi_st,
  output logic [10:0]      cursor,
  output logic             vidmod
);
  localparam int DEPTH = 1 << KBD_AW;

  logic [15:0] offs;
  logic [2:0]  off;
  logic        hit, pop, push_ok, flush, empty, full;

  logic [DEPTH-1:0][7:0] fifo_q, fifo_d;
  logic [KBD_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [KBD_AW:0]       count_q, count_d;
  logic                  ovf_q, ovf_d, intr_q, intr_d, irq_en_q, irq_en_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d, mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d, mem_sel_q, mem_sel_d;
  logic [7:0]            mem_d_q, mem_d_d, spi_out_q, spi_out_d;
  logic [1:0]            spi_cmd_q, spi_cmd_d;
  logic                  spi_sent_q, spi_sent_d, vidmod_q, vidmod_d;
  logic [10:0]           cursor_q, cursor_d;

  // Unsigned subtract also rejects addresses below BASE (they wrap high).
  assign offs  = address - BASE;
  assign hit   = (offs < 16'd8);
  assign off   = offs[2:0];
  assign empty = (count_q == '0);
  assign full  = (count_q == (KBD_AW+1)'(DEPTH));
  assign pop   = rd && hit && (off == 3'd0) && !empty;
  assign flush = we && hit && (off == 3'd6) && data_w[0];
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok = ps2_hit && (!full || pop);

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    intr_d   = intr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        fifo_d[wr_ptr_q] = ps2_data;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        intr_d           = intr_q ^ irq_en_q;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{KBD_AW{1'b0}}, push_ok} - {{KBD_AW{1'b0}}, pop};
    end
    if (we && hit && off == 3'd6 && data_w[1]) ovf_d = 1'b0;
    if (ps2_hit && !push_ok && !flush) ovf_d = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    mem_we_d   = 1'b0;
    mem_sel_d  = mem_sel_q;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    spi_out_d  = spi_out_q;
    spi_cmd_d  = spi_cmd_q;
    spi_sent_d = 1'b0;
    cursor_d   = cursor_q;
    vidmod_d   = vidmod_q;
    irq_en_d   = irq_en_q;
    if (we && hit) begin
      case (off)
        3'd0: begin
          mem_addr_d = ptr_q;
          mem_d_d    = data_w;
          mem_sel_d  = vidmod_q;
          // Hi-res pixels are 4 bits; larger values are skipped but still advance.
          mem_we_d   = !(vidmod_q && data_w >= 8'h10);
          ptr_d      = ptr_q + 1'b1;
        end
        3'd1: ptr_d = {ptr_q[PTR_W-9:0], data_w};
        3'd2: spi_out_d = data_w;
        3'd3: begin
          spi_cmd_d  = data_w[1:0];
          spi_sent_d = 1'b1;
        end
        3'd4: cursor_d = {cursor_q[2:0], data_w};
        3'd5: vidmod_d = data_w[0];
        3'd7: irq_en_d = data_w[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      intr_q     <= 1'b0;
      irq_en_q   <= 1'b1;
      ptr_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      spi_out_q  <= '0;
      spi_cmd_q  <= '0;
      spi_sent_q <= 1'b0;
      cursor_q   <= '0;
      vidmod_q   <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      intr_q     <= intr_d;
      irq_en_q   <= irq_en_d;
      ptr_q      <= ptr_d;
      mem_we_q   <= mem_we_d;
      mem_sel_q  <= mem_sel_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      spi_out_q  <= spi_out_d;
      spi_cmd_q  <= spi_cmd_d;
      spi_sent_q <= spi_sent_d;
      cursor_q   <= cursor_d;
      vidmod_q   <= vidmod_d;
    end
  end

  always_comb begin
    data_r = 8'h00;
    if (!hit) data_r = ram_q;
    else begin
      case (off)
        3'd0: data_r = empty ? 8'h00 : fifo_q[rd_ptr_q];
        3'd1: data_r = vidmod_q ? {4'h0, himm_q} : font_q;
        3'd2: data_r = spi_din;
        3'd3: data_r = {spi_st[0], spi_st[1], empty, full, ovf_q, 3'b000};
        3'd5: data_r = {7'b0, vidmod_q};
        3'd6: data_r = 8'(count_q);
        3'd7: data_r = {7'b0, irq_en_q};
        default: data_r = 8'h00;
      endcase
    end
  end

  assign intr     = intr_q;
  assign mem_we   = mem_we_q;
  assign mem_sel  = mem_sel_q;
  assign mem_addr = mem_addr_q;
  assign mem_d    = mem_d_q;
  assign spi_out  = spi_out_q;
  assign spi_cmd  = spi_cmd_q;
  assign spi_sent = spi_sent_q;
  assign cursor   = cursor_q;
  assign vidmod   = vidmod_q;
endmodule

// File: tb/tb_port_hub.sv
// Bench for port_hub: video writes scored through a queue, keyboard FIFO
// checked against a queue model, plus register/decode/reset checks.
module tb_port_hub;
  localparam logic [15:0] BASE = 16'h0020;
  localparam int PTR_W = 18;

  logic clock = 1'b0, reset_n = 1'b0;
  logic [15:0] address = '0;
  logic [7:0]  data_w = '0, ram_q = 8'h3C, ps2_data = '0, font_q = 8'h5A, spi_din = 8'hC3;
  logic we = 0, rd = 0, ps2_hit = 0;
  logic [3:0]  himm_q = 4'hC;
  logic [1:0]  spi_st = 2'b00;
  logic [7:0]  data_r, mem_d, spi_out;
  logic        intr, mem_we, mem_sel, spi_sent, vidmod;
  logic [PTR_W-1:0] mem_addr;
  logic [1:0]  spi_cmd;
  logic [10:0] cursor;

  port_hub #(.BASE(BASE), .PTR_W(PTR_W), .KBD_AW(4)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_w(data_w),
    .we(we), .rd(rd), .ram_q(ram_q), .data_r(data_r), .intr(intr),
    .ps2_data(ps2_data), .ps2_hit(ps2_hit), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_d(mem_d), .font_q(font_q), .himm_q(himm_q),
    .spi_out(spi_out), .spi_cmd(spi_cmd), .spi_sent(spi_sent), .spi_din(spi_din),
    .spi_st(spi_st), .cursor(cursor), .vidmod(vidmod)
  );

  always #20 clock = ~clock;

  typedef struct { int cyc; logic [PTR_W-1:0] a; logic [7:0] d; logic s; } mw_t;
  mw_t sb[$];
  logic [7:0] kq[$];
  logic [PTR_W-1:0] ptr_m = '0;
  logic vm_m = 0, ovf_m = 0, intr_m = 0, irq_m = 1;
  int cyc = 0, n_chk = 0, n_err = 0, n_sent = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (spi_sent === 1'b1) n_sent++;
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) chk("mem_we_spurious", 1, 0);
      else begin
        mw_t e;
        e = sb.pop_front();
        chk("mem_latency", 64'(cyc), 64'(e.cyc));
        chk("mem_addr", mem_addr, e.a);
        chk("mem_d", mem_d, e.d);
        chk("mem_sel", mem_sel, e.s);
      end
    end
  end

  function automatic logic [7:0] stat_m();
    return {spi_st[0], spi_st[1], kq.size() == 0, kq.size() == 16, ovf_m, 3'b000};
  endfunction

  // One bus cycle: drive at negedge, update the model, release strobes after posedge.
  task automatic bus(input bit w, input bit r, input int off, input logic [7:0] d,
                     input bit k, input logic [7:0] code);
    bit pop_m, full_m;
    @(negedge clock);
    address = 16'(BASE + 16'(off)); data_w = d; we = w; rd = r;
    ps2_hit = k; ps2_data = code;
    if (r && off == 0) begin
      #1 chk("kbd_head", data_r, (kq.size() > 0) ? kq[0] : 8'h00);
    end
    pop_m  = r && off == 0 && kq.size() > 0;
    full_m = kq.size() == 16;
    if (w && off == 6 && d[1]) ovf_m = 0;
    if (w && off == 6 && d[0]) kq.delete();
    else begin
      if (pop_m) void'(kq.pop_front());
      if (k) begin
        if (!full_m || pop_m) begin
          kq.push_back(code);
          if (irq_m) intr_m = ~intr_m;
        end else ovf_m = 1;
      end
    end
    if (w) begin
      case (off)
        0: begin
          if (!(vm_m && d >= 8'h10)) sb.push_back('{cyc + 1, ptr_m, d, vm_m});
          ptr_m = ptr_m + 1'b1;
        end
        1: ptr_m = {ptr_m[PTR_W-9:0], d};
        5: vm_m = d[0];
        7: irq_m = d[0];
        default: ;
      endcase
    end
    @(posedge clock); #1;
    we = 0; rd = 0; ps2_hit = 0;
  endtask

  task automatic wr(input int off, input logic [7:0] d); bus(1, 0, off, d, 0, 8'h00); endtask
  task automatic push(input logic [7:0] c); bus(0, 0, 0, 8'h00, 1, c); endtask
  task automatic pop(); bus(0, 1, 0, 8'h00, 0, 8'h00); endtask

  task automatic rdc(input string tag, input int off, input logic [7:0] exp);
    @(negedge clock);
    address = 16'(BASE + 16'(off));
    #1 chk(tag, data_r, exp);
  endtask

  task automatic kbd_state(input string tag);
    rdc({tag, "_count"}, 6, 8'(kq.size()));
    rdc({tag, "_status"}, 3, stat_m());
    chk({tag, "_intr"}, intr, intr_m);
  endtask

  initial begin
    int s0;
    #1 chk("reset_outs", {mem_we, mem_sel, mem_addr, mem_d, spi_out, spi_cmd, spi_sent, cursor, vidmod, intr}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    rdc("reset_irq_en", 7, 8'h01);
    kbd_state("reset");

    // 1: pointer load and back-to-back video writes
    wr(1, 8'h12); wr(1, 8'h34); wr(0, 8'hAA); wr(0, 8'hBB);
    rdc("font_read", 1, 8'h5A);

    // 2: graphics mode, pointer wrap, suppressed write
    wr(1, 8'h03); wr(1, 8'hFF); wr(1, 8'hFF); wr(5, 8'h01);
    chk("vidmod_out", vidmod, 1);
    rdc("vidmod_read", 5, 8'h01);
    rdc("himm_read", 1, 8'h0C);
    wr(0, 8'h05); wr(0, 8'h20); wr(0, 8'h01);
    wr(5, 8'h00);

    // decode edges
    rdc("out_above", 8, 8'h3C);
    rdc("out_below", -1, 8'h3C);
    rdc("wo_offset4", 4, 8'h00);
    wr(8, 8'h55);
    wr(-1, 8'h55);

    // 3: three scancodes, one pop
    push(8'h1C); push(8'h32); push(8'h21);
    kbd_state("three");
    rdc("head_1c", 0, 8'h1C);
    pop();
    rdc("head_32", 0, 8'h32);
    kbd_state("after_pop");

    // 4: overflow
    wr(6, 8'h01);
    kbd_state("flushed");
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
    kbd_state("overflow");
    wr(6, 8'h02);
    kbd_state("ovf_clr");

    // 5: push+pop when full, drain, pop on empty
    bus(0, 1, 0, 8'h00, 1, 8'h99);
    kbd_state("full_pushpop");
    wr(7, 8'h00);
    rdc("irq_off", 7, 8'h00);
    pop(); push(8'h5D);
    kbd_state("irq_disabled");
    wr(7, 8'h01);
    for (int i = 0; i < 16; i++) pop();
    kbd_state("drained");
    pop();
    kbd_state("empty_pop");
    push(8'h11); push(8'h22);
    bus(1, 0, 6, 8'h01, 1, 8'h77);
    kbd_state("flush_push");

    // 6: SPI, cursor, status
    wr(2, 8'h5E);
    chk("spi_out", spi_out, 8'h5E);
    rdc("spi_din", 2, 8'hC3);
    s0 = n_sent;
    wr(3, 8'h01);
    chk("spi_cmd", spi_cmd, 2'd1);
    rdc("spi_dummy_a", 2, 8'hC3);
    rdc("spi_dummy_b", 2, 8'hC3);
    chk("spi_sent_once", 64'(n_sent - s0), 1);
    wr(4, 8'h07); wr(4, 8'hAB);
    chk("cursor", cursor, 11'h7AB);
    spi_st = 2'b01;
    push(8'h4E);
    rdc("status_80", 3, 8'h80);
    wr(6, 8'h01);
    rdc("status_a0", 3, 8'hA0);
    spi_st = 2'b10;
    rdc("status_timeout", 3, 8'h60);
    spi_st = 2'b00;

    // asynchronous reset while an SPI strobe is live
    wr(5, 8'h01); push(8'h3A); wr(3, 8'h02);
    s0 = n_sent;
    reset_n = 0;
    #1 chk("midreset_outs", {mem_we, mem_sel, mem_addr, mem_d, spi_out, spi_cmd, spi_sent, cursor, vidmod, intr}, 0);
    kq.delete(); ptr_m = '0; vm_m = 0; ovf_m = 0; intr_m = 0; irq_m = 1;
    repeat (2) @(negedge clock);
    chk("midreset_no_sent", 64'(n_sent - s0), 0);
    reset_n = 1;
    kbd_state("post_reset");
    rdc("post_irq_en", 7, 8'h01);
    wr(0, 8'h66);
    repeat (2) @(negedge clock);
    chk("sb_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
